// File: rtl/reduction_pipe_bank.sv
// Elastic valid/ready register bank for the MAC reduction datapath; each rank narrows in lane count.
// Defining PIPE_STATS_EN adds the stall_cnt/beat_cnt statistics outputs.
`timescale 1ns/1ps
module reduction_pipe_bank #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LANES0    = 8,
    parameter int unsigned STAGES    = 4,
    parameter int unsigned MIN_LANES = 2,
    parameter int unsigned ACC_LANE  = 1,
    // Closed-form lane total for up to 8 ranks; must agree with lanes_of()/off_of() below.
    localparam int unsigned TOT =
          ((LANES0 >> 0) > MIN_LANES ? (LANES0 >> 0) : MIN_LANES)
        + (STAGES > 1 ? ((LANES0 >> 1) > MIN_LANES ? (LANES0 >> 1) : MIN_LANES) : 32'd0)
        + (STAGES > 2 ? ((LANES0 >> 2) > MIN_LANES ? (LANES0 >> 2) : MIN_LANES) : 32'd0)
        + (STAGES > 3 ? ((LANES0 >> 3) > MIN_LANES ? (LANES0 >> 3) : MIN_LANES) : 32'd0)
        + (STAGES > 4 ? ((LANES0 >> 4) > MIN_LANES ? (LANES0 >> 4) : MIN_LANES) : 32'd0)
        + (STAGES > 5 ? ((LANES0 >> 5) > MIN_LANES ? (LANES0 >> 5) : MIN_LANES) : 32'd0)
        + (STAGES > 6 ? ((LANES0 >> 6) > MIN_LANES ? (LANES0 >> 6) : MIN_LANES) : 32'd0)
        + (STAGES > 7 ? ((LANES0 >> 7) > MIN_LANES ? (LANES0 >> 7) : MIN_LANES) : 32'd0)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     acc_clear,
    input  logic [TOT*DATA_W-1:0]    d_in,
    output logic [TOT*DATA_W-1:0]    q_out,
    output logic [STAGES-1:0]        stage_load,
    output logic [STAGES-1:0]        stage_vld
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              beat_cnt
`endif
);

    function automatic int unsigned lanes_of(input int unsigned s);
        return ((LANES0 >> s) > MIN_LANES) ? (LANES0 >> s) : MIN_LANES;
    endfunction

    function automatic int unsigned off_of(input int unsigned s);
        int unsigned acc;
        acc = 0;
        for (int unsigned i = 0; i < s; i++) acc += lanes_of(i);
        return acc;
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] rdy, uv, load;

    // Ready folds from the last rank backwards; a scalar accumulator keeps the chain acyclic.
    always_comb begin
        logic down_rdy;
        down_rdy = out_ready;
        rdy      = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            down_rdy                 = down_rdy | ~vld_q[STAGES-1-i];
            rdy[STAGES-1-i]          = down_rdy;
        end
    end

    assign uv   = {vld_q[STAGES-2:0], in_valid};
    assign load = uv & rdy & {STAGES{~flush}};

    always_comb begin
        vld_d = vld_q;
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (flush)                            vld_d[s] = 1'b0;
            else if (load[s])                     vld_d[s] = 1'b1;
            else if (vld_q[s] & rdy[s] & ~uv[s])  vld_d[s] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    assign in_ready   = rdy[0] & ~flush;
    assign out_valid  = vld_q[STAGES-1];
    assign stage_load = load;
    assign stage_vld  = vld_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_rank
        localparam int unsigned L       = lanes_of(s);
        localparam int unsigned OFF     = off_of(s);
        localparam bit          IS_LAST = (s == STAGES - 1);

        logic [L*DATA_W-1:0] rank_d, rank_q;

        // acc_clear overrides the accumulator lane even when the rank loads.
        always_comb begin
            rank_d = rank_q;
            if (load[s]) rank_d = d_in[OFF*DATA_W +: L*DATA_W];
            if (IS_LAST && acc_clear) rank_d[ACC_LANE*DATA_W +: DATA_W] = '0;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) rank_q <= '0;
            else       rank_q <= rank_d;
        end

        assign q_out[OFF*DATA_W +: L*DATA_W] = rank_q;
    end

`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
            beat_cnt_d  = '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
            if (out_valid && out_ready)                        beat_cnt_d  = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_reduction_pipe_bank.sv
// Directed bench for reduction_pipe_bank: default 8,4,2,2 instance plus a 16,8,4,2,2 instance.
`timescale 1ns/1ps
module tb_reduction_pipe_bank;

  localparam int W = 32;

  `define CHK(tag, obs, exp) \
    begin \
      n_tests++; \
      assert ((obs) === (exp)) else begin \
        n_fail++; \
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, (obs), (exp)); \
      end \
    end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic            reset, in_valid, out_ready, flush, acc_clear;
  logic            in_ready, out_valid;
  logic [16*W-1:0] d_in, d_static, q_out;
  logic [3:0]      stage_load, stage_vld;
  logic            chain;
`ifdef PIPE_STATS_EN
  logic [31:0]     stall_cnt, beat_cnt;
`endif

  logic            in_valid6, out_ready6, in_ready6, out_valid6;
  logic [32*W-1:0] d_in6, q_out6;
  logic [4:0]      stage_load6, stage_vld6;
`ifdef PIPE_STATS_EN
  logic [31:0]     stall_cnt6, beat_cnt6;
`endif

  always_comb begin
    d_in = d_static;
    if (chain) begin
      d_in[8*W  +: W] = q_out[0    +: W];
      d_in[12*W +: W] = q_out[8*W  +: W];
      d_in[14*W +: W] = q_out[12*W +: W];
    end
  end

  reduction_pipe_bank dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .acc_clear(acc_clear),
    .d_in(d_in), .q_out(q_out),
    .stage_load(stage_load), .stage_vld(stage_vld)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .beat_cnt(beat_cnt)
`endif
  );

  reduction_pipe_bank #(.LANES0(16), .STAGES(5)) dut6 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .flush(1'b0), .acc_clear(1'b0),
    .d_in(d_in6), .q_out(q_out6),
    .stage_load(stage_load6), .stage_vld(stage_vld6)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt6), .beat_cnt(beat_cnt6)
`endif
  );

  function automatic logic [31:0] lane16(input logic [16*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [31:0] lane32(input logic [32*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int  sent, recv, cnt;
    bit  saw_block;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; acc_clear = 1'b0;
    chain = 1'b0; d_static = '0;
    in_valid6 = 1'b0; out_ready6 = 1'b1; d_in6 = '0;
    #12;
    `CHK("rst_q_zero",   |q_out,    1'b0)
    `CHK("rst_vld",      stage_vld, 4'b0000)
    `CHK("rst_in_ready", in_ready,  1'b1)
    `CHK("rst_out_vld",  out_valid, 1'b0)
    reset = 1'b0;
    tick();

    for (int unsigned i = 0; i < 16; i++) d_static[i*W +: W] = 32'(i);
    in_valid = 1'b1;
    #1;
    `CHK("t1_load0", stage_load, 4'b0001)
    tick();
    in_valid = 1'b0;
    `CHK("t1_vld_c1", stage_vld, 4'b0001)
    `CHK("t1_lane7",  lane16(q_out, 7), 32'd7)
    tick();
    `CHK("t1_vld_c2", stage_vld, 4'b0010)
    tick();
    `CHK("t1_vld_c3", stage_vld, 4'b0100)
    `CHK("t1_ov_c3",  out_valid, 1'b0)
    tick();
    `CHK("t1_vld_c4", stage_vld, 4'b1000)
    `CHK("t1_ov_c4",  out_valid, 1'b1)
    `CHK("t1_lane15", lane16(q_out, 15), 32'd15)
    tick();
    `CHK("t1_ov_c5",  out_valid, 1'b0)

    chain = 1'b1; sent = 0; recv = 0; saw_block = 1'b0;
    for (int unsigned c = 0; c < 40 && recv < 10; c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid  = (sent < 10);
      d_static[0 +: W] = 32'(100 + sent);
      #1;
      if (stage_vld == 4'hF && !out_ready && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        n_tests++;
        if (lane16(q_out, 14) !== 32'(100 + recv)) begin
          n_fail++;
          $error("FAIL t2_order observed=0x%0h expected=0x%0h", lane16(q_out, 14), 32'(100 + recv));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (recv !== 10) begin
      n_fail++;
      $error("FAIL t2_count observed=%0d expected=10", recv);
    end
    n_tests++;
    if (saw_block !== 1'b1) begin
      n_fail++;
      $error("FAIL t2_backpr observed=%0d expected=1", saw_block);
    end
    `CHK("t2_drained", stage_vld, 4'b0000)

    out_ready = 1'b0; in_valid = 1'b1;
    for (int unsigned c = 0; c < 12 && stage_vld != 4'hF; c++) begin
      d_static[0 +: W] = 32'(200 + c);
      tick();
    end
    `CHK("t3_full", stage_vld, 4'hF)
    flush = 1'b1;
    #1;
    `CHK("t3_in_ready_fl", in_ready,   1'b0)
    `CHK("t3_load_fl",     stage_load, 4'b0000)
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    `CHK("t3_vld",      stage_vld, 4'b0000)
    `CHK("t3_in_ready", in_ready,  1'b1)
    `CHK("t3_hold",     lane16(q_out, 14), 32'd200)
    cnt = 0;
    repeat (6) begin
      if (out_valid) cnt++;
      tick();
    end
    n_tests++;
    if (cnt !== 0) begin
      n_fail++;
      $error("FAIL t3_no_out observed=%0d expected=0", cnt);
    end

    chain = 1'b0; out_ready = 1'b0;
    d_static[14*W +: W] = 32'hAAAA_0001;
    d_static[15*W +: W] = 32'h5555_0002;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned c = 0; c < 8 && stage_vld != 4'h8; c++) tick();
    `CHK("t4_vld_last", stage_vld, 4'h8)
    `CHK("t4_l0_pre",   lane16(q_out, 14), 32'hAAAA_0001)
    `CHK("t4_l1_pre",   lane16(q_out, 15), 32'h5555_0002)
    acc_clear = 1'b1;
    #1;
    `CHK("t4_noload", stage_load, 4'b0000)
    tick();
    acc_clear = 1'b0;
    `CHK("t4_l1_clr",  lane16(q_out, 15), 32'h0)
    `CHK("t4_l0_keep", lane16(q_out, 14), 32'hAAAA_0001)
    `CHK("t4_vld_keep", stage_vld, 4'h8)
    d_static[14*W +: W] = 32'h1234_5678;
    d_static[15*W +: W] = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned c = 0; c < 8 && stage_vld != 4'hC; c++) tick();
    `CHK("t4_vld_c", stage_vld, 4'hC)
    out_ready = 1'b1; acc_clear = 1'b1;
    #1;
    `CHK("t4_load_last", stage_load, 4'b1000)
    tick();
    acc_clear = 1'b0;
    `CHK("t4_l0_load",  lane16(q_out, 14), 32'h1234_5678)
    `CHK("t4_l1_load",  lane16(q_out, 15), 32'h0)
    `CHK("t4_vld_post", stage_vld, 4'h8)
    tick();

    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    `CHK("t5_vld_pre", stage_vld, 4'b0010)
    #2 reset = 1'b1;
    #1;
    `CHK("t5_q_zero", |q_out,    1'b0)
    `CHK("t5_vld",    stage_vld, 4'b0000)
    #3 reset = 1'b0;
    tick();
    `CHK("t5_in_ready", in_ready, 1'b1)
    cnt = 0;
    repeat (6) begin
      if (out_valid) cnt++;
      tick();
    end
    n_tests++;
    if (cnt !== 0) begin
      n_fail++;
      $error("FAIL t5_no_out observed=%0d expected=0", cnt);
    end

    d_in6[0  +: W] = 32'h1;
    d_in6[30*W +: W] = 32'hCAFE;
    in_valid6 = 1'b1;
    #1;
    `CHK("t6_load0", stage_load6, 5'b00001)
    tick();
    in_valid6 = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      n_tests++;
      if (stage_vld6 !== 5'(1 << k)) begin
        n_fail++;
        $error("FAIL t6_walk observed=0x%0h expected=0x%0h", stage_vld6, 5'(1 << k));
      end
      n_tests++;
      if (out_valid6 !== (k == 4)) begin
        n_fail++;
        $error("FAIL t6_ov observed=%0d expected=%0d", out_valid6, (k == 4));
      end
      tick();
    end
    `CHK("t6_lane30", lane32(q_out6, 30), 32'hCAFE)
    `CHK("t6_lane0",  lane32(q_out6, 0),  32'h1)
    `CHK("t6_empty",  stage_vld6, 5'b00000)

`ifdef PIPE_STATS_EN
    `CHK("st_stall0", stall_cnt, 32'd0)
    `CHK("st_beat0",  beat_cnt,  32'd0)
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned c = 0; c < 8 && !out_valid; c++) tick();
    `CHK("st_ov", out_valid, 1'b1)
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    `CHK("st_stall3", stall_cnt, 32'd3)
    `CHK("st_beat1",  beat_cnt,  32'd1)
    in_valid = 1'b1;
    repeat (9) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    `CHK("st_beat10",  beat_cnt,  32'd10)
    `CHK("st_stall_k", stall_cnt, 32'd3)
    flush = 1'b1;
    tick();
    flush = 1'b0;
    `CHK("st_stall_fl", stall_cnt, 32'd0)
    `CHK("st_beat_fl",  beat_cnt,  32'd0)
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
